// File: rtl/phase_sincos_cordic.sv
// Pipelined rotation-mode CORDIC: wrapped Q3.45 phase in, rounded/saturated sin/cos out,
// with per-sample block-boundary tagging for the demodulator reference multiplier.
module phase_sincos_cordic #(
    parameter int STAGES = 18,
    parameter int OUT_W  = 18,
    parameter int Z_W    = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Z_W-1:0]   angle_in,
    input  logic             angle_valid,
    input  logic             blk_start,
    input  logic [8:0]       blk_len,
    output logic [OUT_W-1:0] sin_out,
    output logic [OUT_W-1:0] cos_out,
    output logic             out_valid,
    output logic             out_last,
    output logic             range_err
);
    localparam int GUARD = 4;
    localparam int XW    = OUT_W + GUARD;

    localparam logic signed [Z_W-1:0] PI      = Z_W'(48'h6487ED5110B4);
    localparam logic signed [Z_W-1:0] HALF_PI = PI >>> 1;
    localparam logic signed [Z_W-1:0] LIM     = PI + Z_W'(48'h000002000000);
    localparam logic signed [XW-1:0]  X0      = XW'(int'(0.607252935 * 2.0**(OUT_W + 2)));
    localparam logic signed [XW-1:0]  RND     = XW'(1) <<< (GUARD - 1);
    localparam logic signed [XW-1:0]  ONE     = XW'(1) <<< (OUT_W - 2);

    // atan(2^-i) in Q3.45, truncated; beyond i=14 it is 2^(45-i) minus under one LSB
    function automatic logic signed [Z_W-1:0] atan_q(input int i);
        logic [47:0] v;
        case (i)
            0:       v = 48'h1921FB54442D;
            1:       v = 48'd16313149993181;
            2:       v = 48'd8619420437280;
            3:       v = 48'd4375352399237;
            4:       v = 48'd2196166636239;
            5:       v = 48'd1099153923403;
            6:       v = 48'd549711081197;
            7:       v = 48'd274872314743;
            8:       v = 48'd137438254427;
            9:       v = 48'd68719389354;
            10:      v = 48'd34359727445;
            11:      v = 48'd17179867818;
            12:      v = 48'd8589934421;
            13:      v = 48'd4294967274;
            14:      v = 48'd2147483645;
            default: v = (48'd1 << (45 - i)) - 48'd1;
        endcase
        return Z_W'(v);
    endfunction

    function automatic logic [OUT_W-1:0] finish_out(input logic signed [XW-1:0] v, input logic n);
        logic signed [XW-1:0] r;
        r = (v + RND) >>> GUARD;
        if (n) r = -r;
        if (r > ONE) r = ONE;
        else if (r < -ONE) r = -ONE;
        return OUT_W'(r);
    endfunction

    logic signed [Z_W-1:0] ang, z_f;
    logic                  neg_f, oor, last_f;
    logic [8:0]            rem_q, rem_d, rem_eff;

    logic signed [XW-1:0]  x_q [0:STAGES];
    logic signed [XW-1:0]  y_q [0:STAGES];
    logic signed [XW-1:0]  x_d [0:STAGES];
    logic signed [XW-1:0]  y_d [0:STAGES];
    logic signed [Z_W-1:0] z_q [0:STAGES-1];
    logic signed [Z_W-1:0] z_d [0:STAGES-1];
    logic [STAGES:0]       vld_q, last_q, neg_q;

    logic [OUT_W-1:0]      sin_q, cos_q;
    logic                  out_valid_q, out_last_q, range_err_q;

    always_comb begin
        ang   = $signed(angle_in);
        z_f   = ang;
        neg_f = 1'b0;
        if (ang > HALF_PI) begin
            z_f   = ang - PI;
            neg_f = 1'b1;
        end else if (ang < -HALF_PI) begin
            z_f   = ang + PI;
            neg_f = 1'b1;
        end
        oor = (ang > LIM) || (ang < -LIM);

        // a coincident blk_start makes this sample the first of the new block
        rem_eff = blk_start ? blk_len : rem_q;
        last_f  = angle_valid && (rem_eff == 9'd1);
        rem_d   = rem_eff;
        if (angle_valid && rem_eff != 9'd0) rem_d = rem_eff - 9'd1;
    end

    always_comb begin
        x_d[0] = X0;
        y_d[0] = '0;
        z_d[0] = z_f;
        for (int i = 0; i < STAGES; i++) begin
            x_d[i+1] = z_q[i][Z_W-1] ? x_q[i] + (y_q[i] >>> i) : x_q[i] - (y_q[i] >>> i);
            y_d[i+1] = z_q[i][Z_W-1] ? y_q[i] - (x_q[i] >>> i) : y_q[i] + (x_q[i] >>> i);
        end
        for (int i = 1; i < STAGES; i++)
            z_d[i] = z_q[i-1][Z_W-1] ? z_q[i-1] + atan_q(i-1) : z_q[i-1] - atan_q(i-1);
    end

    always_ff @(posedge clk) begin
        x_q   <= x_d;
        y_q   <= y_d;
        z_q   <= z_d;
        neg_q <= {neg_q[STAGES-1:0], neg_f};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            last_q      <= '0;
            rem_q       <= '0;
            range_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sin_q       <= '0;
            cos_q       <= '0;
        end else begin
            vld_q       <= {vld_q[STAGES-1:0], angle_valid};
            last_q      <= {last_q[STAGES-1:0], last_f};
            rem_q       <= rem_d;
            if (angle_valid && oor) range_err_q <= 1'b1;
            out_valid_q <= vld_q[STAGES];
            out_last_q  <= last_q[STAGES];
            if (vld_q[STAGES]) begin
                sin_q <= finish_out(y_q[STAGES], neg_q[STAGES]);
                cos_q <= finish_out(x_q[STAGES], neg_q[STAGES]);
            end
        end
    end

    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign range_err = range_err_q;
endmodule

// File: tb/tb_phase_sincos_cordic.sv
// Bench for phase_sincos_cordic: real-valued sin/cos model, block-position model for out_last.
module tb_phase_sincos_cordic;
    localparam int    LAT  = 20;
    localparam int    TOL  = 2;
    localparam real   PI_R = 3.14159265358979323846;
    localparam logic [47:0] PI48   = 48'h6487ED5110B4;
    localparam logic [47:0] HALF48 = 48'h3243F6A8885A;

    logic        clk = 1'b0, rst = 1'b1, angle_valid = 1'b0, blk_start = 1'b0;
    logic [47:0] angle_in = '0;
    logic [8:0]  blk_len = '0;
    wire signed [17:0] sin_out, cos_out;
    wire         out_valid, out_last, range_err;

    int n_vec = 0, n_err = 0, cyc = 0;

    typedef struct { int s; int c; logic last; int cyc; logic xx; } out_t;
    typedef struct { logic [47:0] a; int cyc; } in_t;
    out_t outq[$];
    in_t  inq[$];

    phase_sincos_cordic dut (
        .clk(clk), .rst(rst), .angle_in(angle_in), .angle_valid(angle_valid),
        .blk_start(blk_start), .blk_len(blk_len), .sin_out(sin_out), .cos_out(cos_out),
        .out_valid(out_valid), .out_last(out_last), .range_err(range_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (out_valid === 1'b1)
            outq.push_back('{int'(sin_out), int'(cos_out), out_last, cyc,
                             $isunknown({sin_out, cos_out, out_last})});

    function automatic void ref_sc(input logic [47:0] a, output int s, output int c);
        real r;
        r = real'(longint'($signed(a))) / (2.0 ** 45);
        s = int'($floor($sin(r) * 65536.0 + 0.5));
        c = int'($floor($cos(r) * 65536.0 + 0.5));
    endfunction

    function automatic logic [47:0] rand_ang();
        real r;
        r = (real'($urandom_range(0, 2000000)) / 1000000.0 - 1.0) * PI_R;
        return 48'(longint'(r * (2.0 ** 45)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [47:0] a, input logic bs, input logic [8:0] bl);
        angle_valid = v; angle_in = a; blk_start = bs; blk_len = bl;
        if (v) inq.push_back('{a, cyc});
        tick();
    endtask

    task automatic idle(input int n);
        angle_valid = 1'b0; blk_start = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_vec += 5;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", out_last); end
        if (range_err !== 1'b0) begin n_err++; $display("FAIL reset_rerr got %b want 0", range_err); end
        if (sin_out !== 18'sd0) begin n_err++; $display("FAIL reset_sin got %0d want 0", sin_out); end
        if (cos_out !== 18'sd0) begin n_err++; $display("FAIL reset_cos got %0d want 0", cos_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_points();
        logic [47:0] a;
        int es, ec;
        out_t o;
        for (int k = 0; k < 11; k++) begin
            case (k)
                0: a = 48'h0;
                1: a = HALF48;
                2: a = -PI48;
                default: a = rand_ang();
            endcase
            ref_sc(a, es, ec);
            outq.delete(); inq.delete();
            drive(1'b1, a, 1'b0, 9'd0);
            idle(LAT + 5);
            n_vec++;
            if (outq.size() != 1) begin
                n_err++; $display("FAIL point%0d_count got %0d want 1", k, outq.size());
                continue;
            end
            o = outq.pop_front();
            n_vec += 4;
            if (o.cyc - inq[0].cyc != LAT) begin n_err++; $display("FAIL point%0d_latency got %0d want %0d", k, o.cyc - inq[0].cyc, LAT); end
            if (o.xx || o.s - es > TOL || es - o.s > TOL) begin n_err++; $display("FAIL point%0d_sin a=%h got %0d want %0d", k, a, o.s, es); end
            if (o.xx || o.c - ec > TOL || ec - o.c > TOL) begin n_err++; $display("FAIL point%0d_cos a=%h got %0d want %0d", k, a, o.c, ec); end
            if (o.last !== 1'b0) begin n_err++; $display("FAIL point%0d_last got %b want 0", k, o.last); end
        end
        n_vec++;
        if (range_err !== 1'b0) begin n_err++; $display("FAIL points_rerr got %b want 0", range_err); end
    endtask

    task automatic test_sweep();
        int es, ec, nbad;
        out_t o;
        outq.delete(); inq.delete();
        for (int k = 0; k < 3600; k++)
            drive(1'b1, 48'(longint'((-180.0 + 0.1 * k) * PI_R / 180.0 * (2.0 ** 45))), 1'b0, 9'd0);
        idle(LAT + 10);
        n_vec++;
        if (outq.size() != 3600) begin n_err++; $display("FAIL sweep_count got %0d want 3600", outq.size()); end
        nbad = 0;
        while (outq.size() > 0 && inq.size() > 0) begin
            o = outq.pop_front();
            ref_sc(inq[0].a, es, ec);
            n_vec += 3;
            if (o.cyc - inq[0].cyc != LAT) begin n_err++; if (nbad++ < 10) $display("FAIL sweep_latency got %0d want %0d", o.cyc - inq[0].cyc, LAT); end
            if (o.xx || o.s - es > TOL || es - o.s > TOL) begin n_err++; if (nbad++ < 10) $display("FAIL sweep_sin a=%h got %0d want %0d", inq[0].a, o.s, es); end
            if (o.xx || o.c - ec > TOL || ec - o.c > TOL) begin n_err++; if (nbad++ < 10) $display("FAIL sweep_cos a=%h got %0d want %0d", inq[0].a, o.c, ec); end
            void'(inq.pop_front());
        end
    endtask

    task automatic test_blocks();
        logic expq[$];
        int len, ns, j;
        out_t o;
        outq.delete(); inq.delete();
        for (int t = 0; t < 10; t++) begin
            case (t)
                0: begin len = 4; ns = 6; end
                1: begin len = 1; ns = 6; end
                2: begin len = 0; ns = 5; end
                default: begin len = $urandom_range(0, 8); ns = $urandom_range(1, 12); end
            endcase
            j = 0;
            while (j < ns) begin
                if (j == 0 || t < 3 || $urandom_range(0, 9) < 7) begin
                    j++;
                    expq.push_back(j == len);
                    drive(1'b1, rand_ang(), j == 1, 9'(len));
                end else begin
                    drive(1'b0, 48'h0, 1'b0, 9'(len));
                end
            end
        end
        idle(LAT + 5);
        n_vec++;
        if (outq.size() != expq.size()) begin n_err++; $display("FAIL blocks_count got %0d want %0d", outq.size(), expq.size()); end
        j = 0;
        while (outq.size() > 0 && expq.size() > 0) begin
            o = outq.pop_front();
            n_vec++;
            if (o.last !== expq[0]) begin n_err++; $display("FAIL blocks_last idx=%0d got %b want %b", j, o.last, expq[0]); end
            void'(expq.pop_front());
            j++;
        end
    endtask

    task automatic test_range_err();
        logic [47:0] lim;
        lim = PI48 + 48'h000002000000;
        outq.delete(); inq.delete();
        drive(1'b1, lim, 1'b0, 9'd0);
        idle(1);
        n_vec++;
        if (range_err !== 1'b0) begin n_err++; $display("FAIL rerr_at_limit got %b want 0", range_err); end
        drive(1'b1, 48'h700000000000, 1'b0, 9'd0);
        n_vec++;
        if (range_err !== 1'b1) begin n_err++; $display("FAIL rerr_set got %b want 1", range_err); end
        idle(LAT + 10);
        n_vec += 3;
        if (range_err !== 1'b1) begin n_err++; $display("FAIL rerr_sticky got %b want 1", range_err); end
        if (outq.size() != 2) begin n_err++; $display("FAIL rerr_outputs got %0d want 2", outq.size()); end
        else if (outq[1].xx) begin n_err++; $display("FAIL rerr_out_x got X want known"); end
        rst = 1'b1; tick(); rst = 1'b0;
        if (range_err !== 1'b0) begin n_err++; $display("FAIL rerr_clear got %b want 0", range_err); end
        drive(1'b1, -lim - 48'd1, 1'b0, 9'd0);
        n_vec++;
        if (range_err !== 1'b1) begin n_err++; $display("FAIL rerr_neg got %b want 1", range_err); end
        idle(LAT + 2);
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++;
        if (range_err !== 1'b0) begin n_err++; $display("FAIL rerr_clear2 got %b want 0", range_err); end
    endtask

    task automatic test_reset_midstream();
        int es, ec;
        out_t o;
        outq.delete(); inq.delete();
        for (int k = 0; k < 10; k++) drive(1'b1, rand_ang(), 1'b0, 9'd0);
        angle_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        inq.delete();
        for (int k = 0; k < 3; k++) drive(1'b1, rand_ang(), 1'b0, 9'd0);
        idle(LAT + 10);
        n_vec++;
        if (outq.size() != 3) begin n_err++; $display("FAIL midrst_count got %0d want 3", outq.size()); end
        while (outq.size() > 0 && inq.size() > 0) begin
            o = outq.pop_front();
            ref_sc(inq[0].a, es, ec);
            n_vec += 3;
            if (o.cyc - inq[0].cyc != LAT) begin n_err++; $display("FAIL midrst_latency got %0d want %0d", o.cyc - inq[0].cyc, LAT); end
            if (o.xx || o.s - es > TOL || es - o.s > TOL) begin n_err++; $display("FAIL midrst_sin got %0d want %0d", o.s, es); end
            if (o.xx || o.c - ec > TOL || ec - o.c > TOL) begin n_err++; $display("FAIL midrst_cos got %0d want %0d", o.c, ec); end
            void'(inq.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_points();
        test_sweep();
        test_blocks();
        test_range_err();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
